// File: rtl/mult_scheduler.sv
// mult_scheduler: two-requester round-robin front end for an external combinational
// 32x32 multiplier. Operands are registered onto mul_a/mul_b, held for MUL_LAT cycles,
// then the product is captured and offered back to the granted requester.
// Optional feature: define MULT_SCHED_SIGNED_EN to add per-requester signed operation.
module mult_scheduler #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
`ifdef MULT_SCHED_SIGNED_EN
    input  logic [1:0]  req_signed,
`endif
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [63:0] rsp_data,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_q, gnt_d;
    logic        neg_q, neg_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic        busy_q, busy_d;

    logic        gnt_sel;
    logic        fire;
    logic [31:0] sel_a, sel_b;
    logic [31:0] op_a, op_b;
    logic        op_neg;

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        if (req_valid == 2'b11) begin
            gnt_sel = ~last_grant_q;
        end else begin
            gnt_sel = req_valid[1];
        end
    end

    // Accept only in idle; gated by rst_n so the port reads zero during reset.
    always_comb begin
        req_ready = 2'b00;
        if (state_q == StIdle && (|req_valid) && rst_n) begin
            req_ready = gnt_sel ? 2'b10 : 2'b01;
        end
        fire = |(req_valid & req_ready);
    end

    // Operand select plus optional sign-magnitude conversion.
    always_comb begin
        sel_a = gnt_sel ? req1_a : req0_a;
        sel_b = gnt_sel ? req1_b : req0_b;
`ifdef MULT_SCHED_SIGNED_EN
        // -2^31 negates to itself, which as unsigned is the correct magnitude 2^31.
        op_a   = (req_signed[gnt_sel] && sel_a[31]) ? (~sel_a + 32'd1) : sel_a;
        op_b   = (req_signed[gnt_sel] && sel_b[31]) ? (~sel_b + 32'd1) : sel_b;
        op_neg = req_signed[gnt_sel] && (sel_a[31] ^ sel_b[31]);
`else
        op_a   = sel_a;
        op_b   = sel_b;
        op_neg = 1'b0;
`endif
    end

    // Next-state and registered-output computation for the three-state FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        neg_d        = neg_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        unique case (state_q)
            StIdle: begin
                if (fire) begin
                    mul_a_d = op_a;
                    mul_b_d = op_b;
                    neg_d   = op_neg;
                    gnt_d   = gnt_sel;
                    cnt_d   = 4'(MUL_LAT);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd1) begin
                    rsp_data_d  = neg_q ? (~mul_result + 64'd1) : mul_result;
                    rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
                    cnt_d       = 4'd0;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                // Only the served requester's ready completes the response.
                if (rsp_ready[gnt_q]) begin
                    last_grant_d = gnt_q;
                    rsp_valid_d  = 2'b00;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State register with asynchronous active-low reset; last_grant resets to 1 so
    // requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            neg_q        <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= 64'd0;
            mul_a_q      <= 32'd0;
            mul_b_q      <= 32'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            neg_q        <= neg_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Self-checking bench for mult_scheduler: reset state, contention order and spacing,
// a table of directed vectors, mid-operation reset and randomized transactions checked
// against a transaction-level model (round-robin rule, full 64-bit product, fixed latency).
module tb_mult_scheduler;

    localparam int unsigned L = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_data;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_result;
    logic        busy;
`ifdef MULT_SCHED_SIGNED_EN
    logic [1:0]  sgn_drv = 2'b00;
`endif

    int errors = 0;
    int checks = 0;
    int last_served;

    always #5 clk = ~clk;

    // External combinational multiplier.
    assign mul_result = {32'd0, mul_a} * {32'd0, mul_b};

    mult_scheduler #(.MUL_LAT(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
`ifdef MULT_SCHED_SIGNED_EN
        .req_signed (sgn_drv),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction: request, wait for result, optional backpressure, accept.
    task automatic do_txn(input logic [1:0] valid, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1, input int delay,
                          input int exp_g, input logic [63:0] exp_p, input bit chk_ops);
        logic [1:0]  oh;
        logic [63:0] held;
        int          k;
        oh = (exp_g == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        req_valid = valid;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        rsp_ready = 2'b00;
        #1;
        chk("grant", 64'(req_ready), 64'(oh));
        @(negedge clk);
        req_valid = 2'b00;
        chk("busy_wait", 64'(busy), 64'd1);
        k = 0;
        while (rsp_valid == 2'b00 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 64'(k), 64'(L));
        chk("rsp_valid", 64'(rsp_valid), 64'(oh));
        chk("rsp_data", rsp_data, exp_p);
        if (chk_ops) begin
            chk("mul_a", 64'(mul_a), 64'((exp_g == 1) ? a1 : a0));
            chk("mul_b", 64'(mul_b), 64'((exp_g == 1) ? b1 : b0));
        end
        held = rsp_data;
        for (int i = 0; i < delay; i++) begin
            // The other requester's ready and fresh requests must both be ignored.
            req_valid = 2'b11;
            rsp_ready = ~oh;
            @(negedge clk);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_data", rsp_data, held);
            chk("bp_busy", 64'(busy), 64'd1);
            chk("bp_valid", 64'(rsp_valid), 64'(oh));
        end
        req_valid = 2'b00;
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = 2'b00;
        chk("rsp_clear", 64'(rsp_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        if (chk_ops) chk("hold_a", 64'(mul_a), 64'((exp_g == 1) ? a1 : a0));
        last_served = exp_g;
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0, b0, a1, b1;
        int          delay;
        int          exp_g;
        logic [63:0] exp_p;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          n, cyc, prev, k, g, mask, eg;
        logic [31:0] ra0, rb0, ra1, rb1;
        logic [63:0] ep;

        // Directed table; expected grants assume requester 0 was served last on entry.
        vecs[0] = '{2'b01, 32'd7, 32'd9, 32'd0, 32'd0, 0, 0, 64'd63};
        vecs[1] = '{2'b11, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1,
                    64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{2'b11, 32'h0001_0000, 32'h0001_0000, 32'd5, 32'd5, 0, 0,
                    64'h0000_0001_0000_0000};
        vecs[3] = '{2'b10, 32'd1, 32'd1, 32'h8000_0000, 32'd2, 2, 1, 64'h0000_0001_0000_0000};
        vecs[4] = '{2'b01, 32'd0, 32'hDEAD_BEEF, 32'd1, 32'd1, 5, 0, 64'd0};
        vecs[5] = '{2'b11, 32'd9, 32'd9, 32'h1234_5678, 32'h10, 0, 1, 64'h0000_0001_2345_6780};

        // Reset with both requesters already valid.
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        req0_a = 32'd3; req0_b = 32'd4; req1_a = 32'd5; req1_b = 32'd6;
        last_served = 1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // Contention from reset: order 0,1,0 at minimum spacing MUL_LAT+2.
        n = 0; cyc = 0; prev = 0;
        while (n < 3 && cyc < 60) begin
            #1;
            if (rsp_valid != 2'b00)
                chk("cont_data", rsp_data, (rsp_valid == 2'b10) ? 64'd30 : 64'd12);
            if ((req_valid & req_ready) != 2'b00) begin
                g = req_ready[1] ? 1 : 0;
                chk("cont_order", 64'(g), 64'(n % 2));
                if (n > 0) chk("cont_spacing", 64'(cyc - prev), 64'(L + 2));
                prev = cyc;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 2'b00;
        chk("cont_count", 64'(n), 64'd3);
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("cont_drain", 64'(busy), 64'd0);
        rsp_ready = 2'b00;
        last_served = 0;

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].valid, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                   vecs[i].delay, vecs[i].exp_g, vecs[i].exp_p, 1'b1);
        end

        // Reset in the middle of WAIT: everything clears, no response, requester 0 wins next.
        @(negedge clk);
        req_valid = 2'b01; req0_a = 32'd11; req0_b = 32'd13;
        @(negedge clk);
        req_valid = 2'b11;
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_req_ready", 64'(req_ready), 64'd0);
        chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mr_rsp_data", rsp_data, 64'd0);
        chk("mr_mul_a", 64'(mul_a), 64'd0);
        chk("mr_mul_b", 64'(mul_b), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b1;
        last_served = 1;
        for (int i = 0; i < int'(L) + 3; i++) begin
            @(negedge clk);
            chk("mr_no_rsp", 64'(rsp_valid), 64'd0);
        end
        do_txn(2'b11, 32'd21, 32'd2, 32'd8, 32'd8, 0, 0, 64'd42, 1'b1);

`ifdef MULT_SCHED_SIGNED_EN
        sgn_drv = 2'b01;
        do_txn(2'b01, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        sgn_drv = 2'b10;
        do_txn(2'b10, 32'd0, 32'd0, 32'h8000_0000, 32'h8000_0000, 0, 1,
               64'h4000_0000_0000_0000, 1'b0);
        sgn_drv = 2'b00;
`endif

        // Randomized transactions against the round-robin / product model.
        for (int i = 0; i < 40; i++) begin
            mask = $urandom_range(1, 3);
            ra0 = $urandom; rb0 = $urandom; ra1 = $urandom; rb1 = $urandom;
            if ($urandom_range(0, 7) == 0) ra0 = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) rb1 = 32'hFFFF_FFFF;
            if (mask == 3) eg = (last_served == 0) ? 1 : 0;
            else eg = (mask == 2) ? 1 : 0;
            ep = (eg == 1) ? (64'(ra1) * 64'(rb1)) : (64'(ra0) * 64'(rb0));
            do_txn(2'(mask), ra0, rb0, ra1, rb1, $urandom_range(0, 3), eg, ep, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter MUL_LAT, default 2: cycles the operands are held on mul_a/mul_b before mul_result is captured; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester operation request; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; at most one bit high in any cycle.
REQ-006 req0_a, req0_b  input  32 each  operands of requester 0.
REQ-007 req1_a, req1_b  input  32 each  operands of requester 1.
REQ-008 rsp_valid  output  2  per-requester result valid; at most one bit high in any cycle.
REQ-009 rsp_ready  input  2  per-requester result accept.
REQ-010 rsp_data  output  64  product; meaningful only while a rsp_valid bit is high.
REQ-011 mul_a, mul_b  output  32 each  registered operands to the external combinational 32x32 multiplier.
REQ-012 mul_result  input  64  product returned by the external multiplier.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 In IDLE, with any req_valid bit high, req_ready SHALL be asserted combinationally for the granted requester only.
REQ-016 Grant SHALL be round-robin: with both requesters valid, grant the one not granted last; with one valid, grant it.
REQ-017 A transfer occurs on an edge where req_valid[g] and req_ready[g] are both high. That edge SHALL register the granted operands into mul_a/mul_b, load the wait counter with MUL_LAT, and enter WAIT.
REQ-018 WAIT SHALL decrement the counter each cycle.
REQ-019 On the edge where the counter equals 1, the block SHALL capture mul_result into rsp_data and enter RESP. For a transfer at edge N, the capture edge is N+MUL_LAT.
REQ-020 In RESP, rsp_valid[g] SHALL be high and rsp_data SHALL be held stable until an edge with rsp_ready[g] high. That edge SHALL update last_grant to g, clear rsp_valid and return to IDLE.
REQ-021 No request SHALL be accepted in WAIT or RESP; req_ready SHALL be 0 outside IDLE.
REQ-022 rsp_ready on a non-granted requester SHALL be ignored.
REQ-023 Deasserting req_valid before its handshake is legal and SHALL have no effect.
REQ-024 mul_a/mul_b SHALL hold their last values in IDLE.
REQ-025 Products SHALL be the full 64-bit value with no truncation.
REQ-026 Minimum spacing between transfers SHALL be MUL_LAT+2 cycles, achieved when rsp_ready is already high on entering RESP.

Reset
REQ-027 rst_n low SHALL asynchronously force the following, regardless of the state at assertion (a mid-operation reset aborts the operation and produces no response):
- FSM to IDLE
- wait counter to 0
- last_grant to 1, so requester 0 wins the first contention
- req_ready, rsp_valid, rsp_data, mul_a, mul_b and busy to 0

Configuration
REQ-028 Macro MULT_SCHED_SIGNED_EN, when defined, SHALL:
- add input port req_signed (2 bits), sampled with the operands at transfer;
- for a signed request, drive operand magnitudes on mul_a/mul_b (-2^31 maps to magnitude 2^31);
- negate the captured product (two's complement, 64-bit) when the operand signs differ.
REQ-029 When MULT_SCHED_SIGNED_EN is undefined, the req_signed port SHALL be absent and all operations SHALL be unsigned.

Verification
REQ-030 Single request: requester 0 issues 7 x 9 with MUL_LAT=2 -> capture at accept edge +2, then rsp_valid=2'b01 with rsp_data=63.
REQ-031 Contention: both requesters valid from reset -> requester 0 served first, then requester 1, then requester 0 again while both stay valid.
REQ-032 Backpressure: hold rsp_ready low for 5 cycles -> rsp_data stays constant, req_ready stays 2'b00, busy stays 1.
REQ-033 Max unsigned: 0xFFFFFFFF x 0xFFFFFFFF -> rsp_data = 0xFFFFFFFE00000001.
REQ-034 Reset mid-WAIT: assert rst_n=0 -> all outputs 0 immediately, no response after release; the next contention grants requester 0.
REQ-035 With MULT_SCHED_SIGNED_EN: signed -3 x 5 -> rsp_data = 0xFFFFFFFFFFFFFFF1; signed 0x80000000 x 0x80000000 -> rsp_data = 0x4000000000000000.
